// File: rtl/npu_dispatch_pkg.sv
// Shared definitions for the NPU operand dispatcher: parameter defaults and FSM state encodings.
package npu_dispatch_pkg;

    localparam int DATA_SIZE_DEF = 32;
    localparam int DEPTH_DEF     = 4;
    localparam int TIMEOUT_DEF   = 64;
    localparam int CNT_W_DEF     = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_GAP   = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ABORT = 3'd4;

endpackage

// File: rtl/npu_dispatch_if.sv
// Host push channel and NPU en/in1/in2/ack channel of the dispatcher.
// push: pair transfers on a cycle with push_valid & push_ready; npu: pair held with en until ack.
interface npu_dispatch_if #(
    parameter int DATA_SIZE = 32
);
    logic                 push_valid;
    logic [DATA_SIZE-1:0] push_a;
    logic [DATA_SIZE-1:0] push_b;
    logic                 push_ready;
    logic                 npu_en;
    logic [DATA_SIZE-1:0] npu_in1;
    logic [DATA_SIZE-1:0] npu_in2;
    logic                 npu_ack;

    modport master (
        input  push_valid, push_a, push_b, npu_ack,
        output push_ready, npu_en, npu_in1, npu_in2
    );

    modport slave (
        output push_valid, push_a, push_b, npu_ack,
        input  push_ready, npu_en, npu_in1, npu_in2
    );
endinterface

// File: rtl/npu_dispatch_op_fifo.sv
// Synchronous operand-pair FIFO with flush; flush wins over a push in the same cycle.
module npu_op_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/npu_dispatch.sv
// Initiator of the NPU operand interface: queues host pairs and issues them one at a time on go.
module npu_dispatch
    import npu_dispatch_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    npu_dispatch_if.master   bus,
    input  logic             go,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [2:0]       state_dbg
);
    localparam int TW = $clog2(TIMEOUT);

    logic [2:0]             state;
    logic [2:0]             state_nx;
    logic [TW-1:0]          timer;
    logic [DATA_SIZE-1:0]   in1_q;
    logic [DATA_SIZE-1:0]   in2_q;
    logic [2*DATA_SIZE-1:0] head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   ack_take;
    logic                   timed_out;

    assign ack_take  = (state == ST_ISSUE) && bus.npu_ack;
    assign timed_out = (timer == TW'(TIMEOUT - 1));

    // push_ready is gated by rst so the host sees nothing accepted while reset is held
    assign bus.push_ready = rst && !fifo_full;
    assign bus.npu_en     = (state == ST_ISSUE);
    assign bus.npu_in1    = in1_q;
    assign bus.npu_in2    = in2_q;
    assign busy           = (state == ST_ISSUE) || (state == ST_GAP);
    assign done           = (state == ST_DONE);
    assign state_dbg      = state;

    npu_op_fifo #(
        .W     (2*DATA_SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.push_valid && bus.push_ready),
        .push_data ({bus.push_a, bus.push_b}),
        .pop       (ack_take),
        .flush     (state == ST_ABORT),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (go) state_nx = fifo_empty ? ST_DONE : ST_ISSUE;
            ST_ISSUE: begin
                if (bus.npu_ack)    state_nx = ST_GAP;
                else if (timed_out) state_nx = ST_ABORT;
            end
            ST_GAP:   state_nx = fifo_empty ? ST_DONE : ST_ISSUE;
            ST_DONE:  state_nx = ST_IDLE;
            ST_ABORT: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            timer      <= '0;
            issued_cnt <= '0;
            err        <= 1'b0;
            in1_q      <= '0;
            in2_q      <= '0;
        end else begin
            state <= state_nx;
            timer <= (state == ST_ISSUE) ? timer + 1'b1 : '0;
            if ((state == ST_IDLE) && go) begin
                err        <= 1'b0;
                issued_cnt <= '0;
            end else if (ack_take) begin
                issued_cnt <= issued_cnt + 1'b1;
            end
            if ((state == ST_ISSUE) && (state_nx == ST_ABORT)) begin
                err <= 1'b1;
            end
            // operands are captured once per request and held through ISSUE and the idle time after
            if ((state_nx == ST_ISSUE) && (state != ST_ISSUE)) begin
                in1_q <= head[2*DATA_SIZE-1:DATA_SIZE];
                in2_q <= head[DATA_SIZE-1:0];
            end
        end
    end
endmodule

// File: tb/tb_npu_dispatch.sv
// Directed bench for npu_dispatch with a small acking NPU model and an expected-pair queue.
module tb_npu_dispatch;
    import npu_dispatch_pkg::*;

    localparam int DS = 32;

    logic       clk;
    logic       rst;
    logic       go;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] issued_cnt;
    logic [2:0] state_dbg;

    npu_dispatch_if #(.DATA_SIZE(DS)) bus ();

    npu_dispatch dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .go         (go),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .issued_cnt (issued_cnt),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard and NPU model, sampled on the falling edge
    logic [2*DS-1:0] exp_q[$];
    logic [2*DS-1:0] held;
    logic [2*DS-1:0] e;
    logic ack_mode = 1'b1;
    logic prev_acked = 1'b0;
    int   age = 0;
    int   low_cnt = 0;
    int   last_en_len = 0;
    int   rises = 0;
    int   acks = 0;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (bus.npu_en) begin
            age++;
            if (age == 1) begin
                rises++;
                if (prev_acked) check("gap_len", 64'(low_cnt), 64'd1);
                prev_acked = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("npu_in1", 64'(bus.npu_in1), 64'(e[2*DS-1:DS]));
                    check("npu_in2", 64'(bus.npu_in2), 64'(e[DS-1:0]));
                end
                held = {bus.npu_in1, bus.npu_in2};
            end else begin
                check("operand_hold", 64'({bus.npu_in1, bus.npu_in2}), 64'(held));
            end
            bus.npu_ack = ack_mode && (age == 3);
            if (bus.npu_ack) begin
                acks++;
                prev_acked = 1'b1;
            end
            low_cnt = 0;
        end else begin
            if (age != 0) last_en_len = age;
            age = 0;
            bus.npu_ack = 1'b0;
            low_cnt++;
        end
        if (done) begin
            done_cnt++;
            prev_acked = 1'b0;
        end
    end

    // driver tasks: all start and end at negedge + 1
    task automatic push_pair(input logic [DS-1:0] a, input logic [DS-1:0] b,
                             input logic exp_ready, input logic enq);
        bus.push_valid = 1'b1;
        bus.push_a     = a;
        bus.push_b     = b;
        check("push_ready", 64'(bus.push_ready), 64'(exp_ready));
        if (enq) exp_q.push_back({a, b});
        @(negedge clk); #1;
        bus.push_valid = 1'b0;
    endtask

    task automatic do_go();
        go = 1'b1;
        @(negedge clk); #1;
        go = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || bus.npu_en) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("idle_timeout", 64'(n < budget), 64'd1);
        repeat (2) begin
            @(negedge clk); #1;
        end
    endtask

    int d0, r0, a0, n;

    initial begin
        rst = 1'b0;
        go = 1'b0;
        bus.push_valid = 1'b1;
        bus.push_a = 32'hAA;
        bus.push_b = 32'hBB;
        bus.npu_ack = 1'b0;

        // 1: reset held 3 cycles with push_valid high
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_en", 64'(bus.npu_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_cnt", 64'(issued_cnt), 64'd0);
        check("rst_in1", 64'(bus.npu_in1), 64'd0);
        check("rst_in2", 64'(bus.npu_in2), 64'd0);
        check("rst_push_ready", 64'(bus.push_ready), 64'd0);
        check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
        rst = 1'b1;
        bus.push_valid = 1'b0;
        @(negedge clk); #1;
        check("post_rst_ready", 64'(bus.push_ready), 64'd1);
        d0 = done_cnt;
        do_go();
        check("rst_fifo_empty_done", 64'(done), 64'd1);
        check("rst_fifo_no_en", 64'(rises), 64'd0);
        @(negedge clk); #1;

        // 2: three pairs in order
        push_pair(32'd1, 32'd2, 1'b1, 1'b1);
        push_pair(32'd3, 32'd4, 1'b1, 1'b1);
        push_pair(32'd5, 32'd6, 1'b1, 1'b1);
        d0 = done_cnt;
        a0 = acks;
        do_go();
        check("go_latency", 64'(bus.npu_en), 64'd1);
        check("busy_issue", 64'(busy), 64'd1);
        wait_idle(200);
        check("t2_cnt", 64'(issued_cnt), 64'd3);
        check("t2_err", 64'(err), 64'd0);
        check("t2_done_once", 64'(done_cnt - d0), 64'd1);
        check("t2_acks", 64'(acks - a0), 64'd3);
        check("t2_q_empty", 64'(exp_q.size()), 64'd0);
        check("t2_en_len", 64'(last_en_len), 64'd3);

        // 3: fill to full, overflow ignored, push+pop in one cycle
        push_pair(32'h11, 32'h12, 1'b1, 1'b1);
        push_pair(32'h21, 32'h22, 1'b1, 1'b1);
        push_pair(32'h31, 32'h32, 1'b1, 1'b1);
        push_pair(32'h41, 32'h42, 1'b1, 1'b1);
        push_pair(32'h9, 32'h9, 1'b0, 1'b0);
        a0 = acks;
        do_go();
        n = 0;
        while (!(bus.npu_ack && acks == a0 + 2) && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("t3_ack_wait", 64'(n < 100), 64'd1);
        push_pair(32'h51, 32'h52, 1'b1, 1'b1);
        wait_idle(200);
        check("t3_cnt", 64'(issued_cnt), 64'd5);
        check("t3_q_empty", 64'(exp_q.size()), 64'd0);

        // 4: timeout abort flushes, next go clears err
        ack_mode = 1'b0;
        push_pair(32'hA1, 32'hA2, 1'b1, 1'b1);
        push_pair(32'hB1, 32'hB2, 1'b1, 1'b0);
        d0 = done_cnt;
        do_go();
        wait_idle(300);
        check("t4_en_len", 64'(last_en_len), 64'd64);
        check("t4_err", 64'(err), 64'd1);
        check("t4_no_done", 64'(done_cnt - d0), 64'd0);
        check("t4_cnt", 64'(issued_cnt), 64'd0);
        check("t4_en_low", 64'(bus.npu_en), 64'd0);
        ack_mode = 1'b1;
        push_pair(32'hC1, 32'hC2, 1'b1, 1'b1);
        do_go();
        check("t4_err_clear", 64'(err), 64'd0);
        wait_idle(200);
        check("t4_cnt_after", 64'(issued_cnt), 64'd1);
        check("t4_q_empty", 64'(exp_q.size()), 64'd0);

        // 5: go with empty FIFO
        r0 = rises;
        d0 = done_cnt;
        do_go();
        check("t5_done", 64'(done), 64'd1);
        check("t5_en", 64'(bus.npu_en), 64'd0);
        repeat (3) begin
            @(negedge clk); #1;
        end
        check("t5_no_issue", 64'(rises - r0), 64'd0);
        check("t5_cnt", 64'(issued_cnt), 64'd0);
        check("t5_done_once", 64'(done_cnt - d0), 64'd1);

        // 6: reset during the second of three pairs
        push_pair(32'hD1, 32'hD2, 1'b1, 1'b1);
        push_pair(32'hE1, 32'hE2, 1'b1, 1'b1);
        push_pair(32'hF1, 32'hF2, 1'b1, 1'b1);
        r0 = rises;
        do_go();
        n = 0;
        while (!(bus.npu_en && rises == r0 + 2) && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("t6_second_wait", 64'(n < 100), 64'd1);
        rst = 1'b0;
        @(negedge clk); #1;
        check("t6_en_drop", 64'(bus.npu_en), 64'd0);
        check("t6_cnt", 64'(issued_cnt), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk); #1;
        r0 = rises;
        do_go();
        check("t6_fifo_empty_done", 64'(done), 64'd1);
        repeat (3) begin
            @(negedge clk); #1;
        end
        check("t6_no_issue", 64'(rises - r0), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end
endmodule
